error_injector: RTL and testbench
=================================

ERROR_INJECTOR -- requirements
Module: error_injector

Interface
REQ-001 SHALL have parameter N, default 63, codeword length in bits (2..127).
REQ-002 SHALL have parameter LW, default 7, location field width; 2^LW >= N.
REQ-003 SHALL have parameter MAX_NE, default 3, maximum errors per word (1..7).
REQ-004 SHALL have parameter NW, default 2, width of ne; 2^NW > MAX_NE.
REQ-005 SHALL have parameter LFSR_SEED, default 1, nonzero LW-bit LFSR reset value.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port in_valid  input  1  input word and control valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a word.
REQ-010 SHALL have port c_in  input  N  clean codeword.
REQ-011 SHALL have port ne  input  NW  requested error count.
REQ-012 SHALL have port mode  input  2  0 fixed list, 1 burst, 2 random, 3 reserved (treated as 0).
REQ-013 SHALL have port loc  input  MAX_NE*LW  packed locations; loc[LW-1:0] is location 1.
REQ-014 SHALL have port out_valid  output  1  r_out valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts r_out.
REQ-016 SHALL have port r_out  output  N  corrupted codeword, c_in XOR err_mask.
REQ-017 SHALL have port err_mask  output  N  bits actually flipped.
REQ-018 SHALL have port ne_applied  output  NW  number of set bits in err_mask.
REQ-019 SHALL have port loc_drop  output  1  at least one requested location was >= N.

Function
REQ-020 SHALL implement FSM IDLE, INJECT, OUT; in_ready = 1 only in IDLE.
REQ-021 SHALL, on in_valid && in_ready, capture c_in, mode, loc and ne clamped to MAX_NE, clear mask, counter and loc_drop; next state OUT if clamped ne = 0, else INJECT.
REQ-022 SHALL, in INJECT, handle one error position per cycle, set (not toggle) that mask bit, and go to OUT on the cycle the ne-th position is handled.
REQ-023 SHALL make out_valid rise ne cycles after the accept edge for fixed and burst modes (1 cycle for ne = 0).
REQ-024 SHALL, in mode 0, use position k = loc field k; duplicate positions collapse to one mask bit.
REQ-025 SHALL, in mode 1, use position k = (loc field 1 + k) mod N, so bursts wrap from bit N-1 to bit 0.
REQ-026 SHALL skip any position >= N without setting a bit, still advance the counter, and set loc_drop.
REQ-027 SHALL hold r_out, err_mask, ne_applied, loc_drop and out_valid stable in OUT until out_ready = 1, then return to IDLE next edge.
REQ-028 SHALL ignore in_valid and all input ports outside IDLE.
REQ-029 SHALL, when out_ready is already high on OUT entry, complete the transfer in that single cycle; back-to-back acceptance occurs on the following IDLE cycle.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force IDLE, clear out_valid, r_out, err_mask, ne_applied, loc_drop and counter to 0, and load the LFSR with LFSR_SEED.
REQ-031 SHALL abandon any in-flight word on reset; the next word after reset release behaves as the first.
REQ-032 SHALL drive in_ready = 1 in the first cycle after reset release.

Configuration
REQ-033 SHALL, with macro ERRINJ_RANDOM_EN defined, implement a maximal-length LW-bit Fibonacci LFSR advancing every clock.
REQ-034 SHALL, with ERRINJ_RANDOM_EN, in mode 2 take the LFSR value as position; values >= N or already set in mask do not advance the counter (retry next cycle), so exactly ne distinct bits are flipped.
REQ-035 SHALL, without ERRINJ_RANDOM_EN, omit the LFSR entirely and treat mode 2 as mode 0.

Verification
REQ-036 SHALL verify: c_in = 0, mode 0, ne = 3, locs 0,1,2 -> after 3 cycles r_out = 0x7, ne_applied = 3, loc_drop = 0.
REQ-037 SHALL verify: mode 1, ne = 3, loc1 = 61, c_in = 0 -> err_mask bits 61, 62, 0 set, ne_applied = 3.
REQ-038 SHALL verify: mode 0, ne = 3, locs 5,5,70 -> err_mask = bit 5 only, ne_applied = 1, loc_drop = 1.
REQ-039 SHALL verify: ne = 0, c_in = all ones -> out_valid 1 cycle after accept, r_out = c_in; out_ready held low 5 cycles -> outputs stable, in_ready = 0.
REQ-040 SHALL verify: rst_n pulsed low during INJECT -> all outputs 0, in_ready = 1 after release, next word correct.
REQ-041 SHALL verify: with ERRINJ_RANDOM_EN, mode 2, ne = 3, 1000 words -> each err_mask has exactly 3 bits, all < N.

Source files
------------

// File: rtl/error_injector_if.sv
`default_nettype none
// ============================================================================
//  Module      : error_injector_if
//  Description : Word-in / word-out handshake bundle for error_injector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface error_injector_if #(
    parameter int N      = 63,
    parameter int LW     = 7,
    parameter int MAX_NE = 3,
    parameter int NW     = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0]           c_in;
    logic [NW-1:0]          ne;
    logic [1:0]             mode;
    logic [MAX_NE*LW-1:0]   loc;
    logic                   out_valid;
    logic                   out_ready;
    logic [N-1:0]           r_out;
    logic [N-1:0]           err_mask;
    logic [NW-1:0]          ne_applied;
    logic                   loc_drop;

    modport master (
        output in_valid, c_in, ne, mode, loc, out_ready,
        input  in_ready, out_valid, r_out, err_mask, ne_applied, loc_drop
    );

    modport slave (
        input  in_valid, c_in, ne, mode, loc, out_ready,
        output in_ready, out_valid, r_out, err_mask, ne_applied, loc_drop
    );
endinterface
`default_nettype wire

// File: rtl/error_injector.sv
`default_nettype none
// ============================================================================
//  Module      : error_injector
//  Description : Flips up to MAX_NE bits of a codeword (fixed list / burst /
//                optional LFSR-random positions). Random mode and its LFSR
//                exist only when ERRINJ_RANDOM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module error_injector #(
    parameter int N         = 63,
    parameter int LW        = 7,
    parameter int MAX_NE    = 3,
    parameter int NW        = 2,
    parameter int LFSR_SEED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    error_injector_if.slave   bus
);

    if (N < 2 || N > 127 || (2**LW) < N || MAX_NE < 1 || MAX_NE > 7 ||
        (2**NW) <= MAX_NE || (LFSR_SEED % (2**LW)) == 0) begin : g_bad_params
        $error("error_injector: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    function automatic logic [NW-1:0] popcount(input logic [N-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += int'(v[i]);
        return NW'(s);
    endfunction

    state_t               state_q, state_d;
    logic [N-1:0]         cw_q, cw_d;
    logic [N-1:0]         mask_q, mask_d;
    logic [N-1:0]         r_out_q, r_out_d;
    logic [MAX_NE*LW-1:0] loc_q, loc_d;
    logic [NW-1:0]        ne_q, ne_d;
    logic [NW-1:0]        cnt_q, cnt_d;
    logic [NW-1:0]        applied_q, applied_d;
    logic                 burst_q, burst_d;
    logic                 drop_q, drop_d;
    logic                 out_valid_q, out_valid_d;

    logic [LW-1:0]        w_fixed_pos;
    logic [LW-1:0]        w_pos;
    logic                 w_pos_ok;
    logic [N-1:0]         w_pos_bit;
    logic                 w_advance;

`ifdef ERRINJ_RANDOM_EN
    // Fibonacci feedback taps for maximal-length sequences, LW = 2..10.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            default: return 16'h0240;
        endcase
    endfunction

    localparam logic [LW-1:0] c_LFSR_TAPS = LW'(lfsr_taps(LW));

    logic [LW-1:0] lfsr_q, lfsr_d;
    logic          rand_q, rand_d;
`endif

    always_comb begin
        w_fixed_pos = '0;
        for (int k = 0; k < MAX_NE; k++) begin
            if (cnt_q == NW'(k)) w_fixed_pos = loc_q[k*LW +: LW];
        end
        w_pos     = burst_q ? LW'((int'(loc_q[LW-1:0]) + int'(cnt_q)) % N) : w_fixed_pos;
        w_advance = 1'b1;
`ifdef ERRINJ_RANDOM_EN
        lfsr_d = {lfsr_q[LW-2:0], ^(lfsr_q & c_LFSR_TAPS)};
        if (rand_q) w_pos = lfsr_q;
`endif
        w_pos_ok  = int'(w_pos) < N;
        w_pos_bit = w_pos_ok ? ({{(N-1){1'b0}}, 1'b1} << w_pos) : '0;
`ifdef ERRINJ_RANDOM_EN
        // Random picks that are out of range or already flipped are retried.
        if (rand_q) w_advance = w_pos_ok && ((mask_q & w_pos_bit) == '0);
`endif

        state_d     = state_q;
        cw_d        = cw_q;
        mask_d      = mask_q;
        r_out_d     = r_out_q;
        loc_d       = loc_q;
        ne_d        = ne_q;
        cnt_d       = cnt_q;
        applied_d   = applied_q;
        burst_d     = burst_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
`ifdef ERRINJ_RANDOM_EN
        rand_d      = rand_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    cw_d    = bus.c_in;
                    loc_d   = bus.loc;
                    ne_d    = (int'(bus.ne) > MAX_NE) ? NW'(MAX_NE) : bus.ne;
                    burst_d = (bus.mode == 2'd1);
`ifdef ERRINJ_RANDOM_EN
                    rand_d  = (bus.mode == 2'd2);
`endif
                    mask_d  = '0;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    if (ne_d == '0) begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        r_out_d     = bus.c_in;
                        applied_d   = '0;
                    end else begin
                        state_d     = ST_INJECT;
                    end
                end
            end
            ST_INJECT: begin
                mask_d = mask_q | w_pos_bit;
                drop_d = drop_q | (w_advance & ~w_pos_ok);
                if (w_advance) begin
                    cnt_d = cnt_q + NW'(1);
                    if (cnt_d == ne_q) begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        r_out_d     = cw_q ^ mask_d;
                        applied_d   = popcount(mask_d);
                    end
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cw_q        <= '0;
            mask_q      <= '0;
            r_out_q     <= '0;
            loc_q       <= '0;
            ne_q        <= '0;
            cnt_q       <= '0;
            applied_q   <= '0;
            burst_q     <= 1'b0;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ERRINJ_RANDOM_EN
            lfsr_q      <= LW'(LFSR_SEED);
            rand_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cw_q        <= cw_d;
            mask_q      <= mask_d;
            r_out_q     <= r_out_d;
            loc_q       <= loc_d;
            ne_q        <= ne_d;
            cnt_q       <= cnt_d;
            applied_q   <= applied_d;
            burst_q     <= burst_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
`ifdef ERRINJ_RANDOM_EN
            lfsr_q      <= lfsr_d;
            rand_q      <= rand_d;
`endif
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.r_out      = r_out_q;
    assign bus.err_mask   = mask_q;
    assign bus.ne_applied = applied_q;
    assign bus.loc_drop   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_error_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_error_injector
//  Description : Randomized, self-checking bench for error_injector against a
//                behavioural model of the injection rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_error_injector;

    localparam int N      = 63;
    localparam int LW     = 7;
    localparam int MAX_NE = 3;
    localparam int NW     = 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    error_injector_if #(.N(N), .LW(LW), .MAX_NE(MAX_NE), .NW(NW)) bus ();

    error_injector #(.N(N), .LW(LW), .MAX_NE(MAX_NE), .NW(NW), .LFSR_SEED(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural model: positions are list entries, or a wrapping run from
    // loc 1 in burst mode; out-of-range positions only raise the drop flag.
    function automatic void model(input logic [N-1:0] c, input int nev, input int md,
                                  input int l[MAX_NE], output logic [N-1:0] m,
                                  output logic [N-1:0] r, output int ap, output logic dr);
        int n;
        int p;
        n  = (nev > MAX_NE) ? MAX_NE : nev;
        m  = '0;
        dr = 1'b0;
        for (int k = 0; k < n; k++) begin
            p = (md == 1) ? (l[0] + k) % N : l[k];
            if (p >= N) dr = 1'b1;
            else        m[p] = 1'b1;
        end
        ap = $countones(m);
        r  = c ^ m;
    endfunction

    function automatic logic [N-1:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[N-1:0];
    endfunction

    // Called and returns at a falling edge with the DUT idle. hold=0 keeps
    // out_ready high so the result is taken on OUT entry.
    task automatic xfer(input logic [N-1:0] c, input int nev, input int md, input int l[MAX_NE],
                        input int hold, output int lat, output logic [N-1:0] r,
                        output logic [N-1:0] m, output int ap, output logic dr,
                        output bit stable, output bit idle_ok, output bit timeout);
        bus.c_in      = c;
        bus.ne        = NW'(nev);
        bus.mode      = 2'(md);
        for (int k = 0; k < MAX_NE; k++) bus.loc[k*LW +: LW] = LW'(l[k]);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = (hold > 0);
        bus.c_in      = rand_word();
        bus.ne        = NW'($urandom);
        bus.mode      = 2'($urandom);
        for (int k = 0; k < MAX_NE; k++) bus.loc[k*LW +: LW] = LW'($urandom);
        lat     = 0;
        timeout = 1'b0;
        stable  = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) break;
            lat++;
            if (lat > 200) begin
                timeout = 1'b1;
                break;
            end
        end
        r  = bus.r_out;
        m  = bus.err_mask;
        ap = int'(bus.ne_applied);
        dr = bus.loc_drop;
        for (int h = 0; h < hold && !timeout; h++) begin
            @(negedge clk);
            if (bus.r_out !== r || bus.err_mask !== m || int'(bus.ne_applied) != ap ||
                bus.loc_drop !== dr || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (hold > 0) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        idle_ok = (bus.in_ready === 1'b1) && (bus.out_valid === 1'b0) && !timeout;
        if (hold > 0) bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.c_in      = '0;
        bus.ne        = '0;
        bus.mode      = '0;
        bus.loc       = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.r_out !== '0 || bus.err_mask !== '0 || bus.ne_applied !== '0 || bus.loc_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: r_out=%h mask=%h ne_applied=%0d drop=%b, want all 0",
                     bus.r_out, bus.err_mask, bus.ne_applied, bus.loc_drop);
        end
        @(negedge clk);
    endtask

    task automatic test_fixed();
        int l[MAX_NE] = '{0, 1, 2};
        int lat, ap;
        logic [N-1:0] r, m;
        logic dr;
        bit st, io, to;
        xfer('0, 3, 0, l, 2, lat, r, m, ap, dr, st, io, to);
        checks++;
        if (to || lat != 3) begin
            errors++;
            $display("FAIL fixed_latency: got %0d cycles (timeout=%0b), want 3", lat, to);
        end
        checks++;
        if (r !== N'(7) || ap != 3 || dr !== 1'b0) begin
            errors++;
            $display("FAIL fixed_result: r_out=%h ne_applied=%0d drop=%b, want 7/3/0", r, ap, dr);
        end
    endtask

    task automatic test_burst_wrap();
        int l[MAX_NE] = '{61, 0, 0};
        int lat, ap;
        logic [N-1:0] r, m, want;
        logic dr;
        bit st, io, to;
        want = '0;
        want[61] = 1'b1;
        want[62] = 1'b1;
        want[0]  = 1'b1;
        xfer('0, 3, 1, l, 1, lat, r, m, ap, dr, st, io, to);
        checks++;
        if (to || m !== want || ap != 3 || r !== want || dr !== 1'b0) begin
            errors++;
            $display("FAIL burst_wrap: mask=%h ne_applied=%0d drop=%b, want mask=%h 3 0", m, ap, dr, want);
        end
    endtask

    task automatic test_dup_drop();
        int l[MAX_NE] = '{5, 5, 70};
        int lat, ap;
        logic [N-1:0] r, m;
        logic dr;
        bit st, io, to;
        xfer(rand_word(), 3, 0, l, 1, lat, r, m, ap, dr, st, io, to);
        checks++;
        if (to || m !== (N'(1) << 5) || ap != 1 || dr !== 1'b1 || lat != 3) begin
            errors++;
            $display("FAIL dup_drop: mask=%h ne_applied=%0d drop=%b lat=%0d, want bit5/1/1/3", m, ap, dr, lat);
        end
    endtask

    task automatic test_hold();
        int l[MAX_NE] = '{3, 4, 5};
        int lat, ap;
        logic [N-1:0] r, m;
        logic dr;
        bit st, io, to;
        xfer('1, 0, 0, l, 5, lat, r, m, ap, dr, st, io, to);
        checks++;
        if (to || lat != 0) begin
            errors++;
            $display("FAIL zero_ne_latency: out_valid seen %0d edges after accept, want 0 (first cycle)", lat);
        end
        checks++;
        if (r !== {N{1'b1}} || m !== '0 || ap != 0) begin
            errors++;
            $display("FAIL zero_ne_result: r_out=%h mask=%h ne_applied=%0d, want all-ones/0/0", r, m, ap);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL hold_stable: outputs moved or in_ready rose while out_ready low (got 0, want 1)");
        end
        checks++;
        if (!io) begin
            errors++;
            $display("FAIL hold_release: in_ready/out_valid after release wrong (got 0, want 1)");
        end
    endtask

    task automatic test_reset_midflight();
        int l[MAX_NE] = '{4, 9, 62};
        int lat, ap, eap;
        logic [N-1:0] c, r, m, em, er;
        logic dr, edr;
        bit st, io, to;
        bus.c_in      = rand_word();
        bus.ne        = NW'(3);
        bus.mode      = 2'd0;
        bus.loc       = {LW'(30), LW'(20), LW'(10)};
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.r_out !== '0 || bus.err_mask !== '0 ||
            bus.ne_applied !== '0 || bus.loc_drop !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset: valid=%b r_out=%h mask=%h ready=%b, want 0/0/0/1",
                     bus.out_valid, bus.r_out, bus.err_mask, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: in_ready=%b, want 1", bus.in_ready);
        end
        @(negedge clk);
        c = rand_word();
        model(c, 3, 0, l, em, er, eap, edr);
        xfer(c, 3, 0, l, 1, lat, r, m, ap, dr, st, io, to);
        checks++;
        if (to || lat != 3 || r !== er || m !== em || ap != eap || dr !== edr) begin
            errors++;
            $display("FAIL post_reset_word: r_out=%h lat=%0d, want %h lat=3", r, lat, er);
        end
    endtask

    // Random words with random ready back-pressure; hold=0 words are taken on
    // OUT entry and the next word is presented on the very next idle cycle.
    task automatic test_random_ref(input int words, input bit back_to_back);
        int l[MAX_NE];
        int lat, ap, eap, nev, md, hold;
        logic [N-1:0] c, r, m, em, er;
        logic dr, edr;
        bit st, io, to;
        for (int w = 0; w < words; w++) begin
            c   = rand_word();
            nev = $urandom_range(0, 3);
`ifdef ERRINJ_RANDOM_EN
            md  = ($urandom_range(0, 2) == 2) ? 3 : $urandom_range(0, 1);
`else
            md  = $urandom_range(0, 3);
`endif
            for (int k = 0; k < MAX_NE; k++) l[k] = $urandom_range(0, 127);
            hold = back_to_back ? 0 : $urandom_range(0, 3);
            model(c, nev, md, l, em, er, eap, edr);
            xfer(c, nev, md, l, hold, lat, r, m, ap, dr, st, io, to);
            checks++;
            if (to || lat != nev) begin
                errors++;
                $display("FAIL rand_latency w%0d: got %0d, want %0d", w, lat, nev);
            end
            checks++;
            if (r !== er || m !== em) begin
                errors++;
                $display("FAIL rand_data w%0d mode%0d: r_out=%h mask=%h, want %h %h", w, md, r, m, er, em);
            end
            checks++;
            if (ap != eap || dr !== edr) begin
                errors++;
                $display("FAIL rand_flags w%0d: ne_applied=%0d drop=%b, want %0d %b", w, ap, dr, eap, edr);
            end
            checks++;
            if (!st || !io) begin
                errors++;
                $display("FAIL rand_handshake w%0d: stable=%0b idle=%0b, want 1 1", w, st, io);
            end
        end
        bus.out_ready = 1'b0;
    endtask

`ifdef ERRINJ_RANDOM_EN
    task automatic test_random_mode();
        int l[MAX_NE] = '{0, 0, 0};
        int lat, ap;
        logic [N-1:0] c, r, m;
        logic dr;
        bit st, io, to;
        for (int w = 0; w < 1000; w++) begin
            c = rand_word();
            xfer(c, 3, 2, l, 0, lat, r, m, ap, dr, st, io, to);
            checks++;
            if (to || $countones(m) != 3 || ap != 3 || dr !== 1'b0 || r !== (c ^ m) || !io) begin
                errors++;
                $display("FAIL random_mode w%0d: mask=%h ones=%0d ne_applied=%0d drop=%b, want 3 distinct bits",
                         w, m, $countones(m), ap, dr);
            end
        end
        bus.out_ready = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fixed();
        test_reset_midflight();
        test_burst_wrap();
        test_dup_drop();
        test_hold();
        test_random_ref(150, 1'b0);
        test_random_ref(40, 1'b1);
`ifdef ERRINJ_RANDOM_EN
        test_random_mode();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
